mem_access: RTL
===============

# mem_access

Memory-access stage sitting directly downstream of the execute stage. It consumes the ALU result (effective address) and the forwarded rs2 value, then runs a request/acknowledge transaction with data memory. It performs RV32I byte-lane alignment for stores and extraction plus sign/zero extension for loads. It stalls the pipeline for the duration of each access and flags misaligned or illegal accesses instead of issuing them.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  a memory instruction is present in this stage.
- i_load  in  1  the instruction is a load.
- i_store  in  1  the instruction is a store.
- i_funct3  in  3  access size and signedness (RV32I encoding).
- i_addr  in  32  effective address (execute ALU output).
- i_storeData  in  32  store source (forwarded rs2).
- o_memReq  out  1  request to data memory; held until acknowledged.
- o_memWe  out  1  write enable; qualifies o_memReq.
- o_memAddr  out  32  word address, {addr[31:2], 2'b00}.
- o_memByteEn  out  4  byte-lane enables.
- o_memWData  out  32  lane-aligned store data.
- i_memAck  in  1  memory completion; sampled only in WAIT.
- i_memRData  in  32  read word; valid in the same cycle as i_memAck.
- o_stall  out  1  holds all upstream stages, combinational.
- o_loadData  out  32  extended load result, registered.
- o_loadValid  out  1  one-cycle pulse when o_loadData is updated.
- o_fault  out  1  one-cycle pulse on a misaligned or illegal access.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset puts the FSM in IDLE.
- A request is an access when i_valid && (i_load ^ i_store).
- IDLE with an access present:
  - If the access is legal and aligned: latch the address, store data, funct3 and direction. Register the memory outputs, then go to WAIT.
  - Otherwise: pulse o_fault, issue no request, stay in IDLE.
- IDLE with i_valid && i_load && i_store: treated as a fault (o_fault pulse), no request.
- WAIT: o_memReq=1 with stable address, enables and data.
  - On i_memAck=1 at a clock edge: drop o_memReq and go to RESP.
  - On that same edge, a load registers o_loadData and sets o_loadValid.
- RESP: o_loadValid=1 for loads only. Inputs are ignored, because the instruction that just completed is still presented. The FSM returns to IDLE.
- Stall: o_stall=1 in IDLE when an accepted access is present, and in all of WAIT. o_stall=0 in RESP and on fault cycles.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Anything else is a fault.
- Misalignment rules:
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<{addr[1],1'b0}.
  - SW/loads: 4'b1111.
- Store data lanes:
  - SB: the low byte replicated ×4.
  - SH: the low halfword replicated ×2.
  - SW: unchanged.
- Load data: shift i_memRData right by 8·addr[1:0], take 8/16/32 bits, then sign-extend (LB/LH) or zero-extend (LBU/LHU).
- Stores leave o_loadData unchanged.
- i_memAck outside WAIT is ignored.

## Timing
- Reset values: o_memReq=0, o_memWe=0, o_memAddr=0, o_memByteEn=0, o_memWData=0, o_loadData=0, o_loadValid=0, o_fault=0. o_stall=0 while in reset.
- Asserting i_rst mid-transaction (WAIT) drops o_memReq immediately and returns to IDLE. No o_loadValid is produced.
- Zero-wait memory (ack in the first WAIT cycle):
  - Cycle 0: IDLE accept, stall=1.
  - Cycle 1: WAIT, req=1, ack=1, stall=1.
  - Cycle 2: RESP, loadValid=1, stall=0.
- Each extra wait cycle adds one cycle.
- Back-to-back accesses: the next access is accepted no earlier than the cycle after RESP.
- o_fault asserts in the same cycle as the offending access (combinational from inputs in IDLE). It never asserts in WAIT or RESP.

## Test plan
- LW addr 0x100, ack in the first WAIT cycle, rdata 0xDEADBEEF:
  - o_memAddr=0x100, byteEn=1111, stall high for 2 cycles.
  - Cycle 2: loadValid=1, loadData=0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 → loadData 0xFFFFFF80. Repeat with LBU → 0x00000080.
- SH addr 0x202, storeData 0x1234ABCD, ack after 3 WAIT cycles:
  - memWe=1, byteEn=1100, wdata=0xABCDABCD, req held for 3 cycles.
  - No loadValid.
- LW addr 0x101; SH addr 0x203; load funct3=011:
  - Each gives a fault pulse the same cycle, req=0 and stall=0.
- i_rst pulsed while in WAIT: req drops asynchronously, and the next access is accepted normally after reset.
- Stray i_memAck while IDLE, then a valid SB to addr 0x3: ignored, then byteEn=1000 and wdata = byte×4.

Source files
------------

// File: rtl/mem_access.sv
// rtl/mem_access.sv - RV32I memory-access stage: req/ack data-memory transactions,
// byte-lane alignment for stores, extraction and extension for loads.
module mem_access #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_valid,
    input  logic            i_load,
    input  logic            i_store,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_addr,
    input  logic [XLEN-1:0] i_storeData,
    output logic            o_memReq,
    output logic            o_memWe,
    output logic [XLEN-1:0] o_memAddr,
    output logic [3:0]      o_memByteEn,
    output logic [XLEN-1:0] o_memWData,
    input  logic            i_memAck,
    input  logic [XLEN-1:0] i_memRData,
    output logic            o_stall,
    output logic [XLEN-1:0] o_loadData,
    output logic            o_loadValid,
    output logic            o_fault
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t          state;
    logic [1:0]      addrLo;
    logic [2:0]      funct3Reg;
    logic            isLoadReg;

    logic            isAccess;
    logic            legalF3;
    logic            misaligned;
    logic            accept;
    logic [3:0]      byteEn;
    logic [XLEN-1:0] laneData;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] extended;

    assign isAccess   = i_valid && (i_load ^ i_store);
    assign legalF3    = i_load ? (i_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                               : (i_funct3 inside {3'b000, 3'b001, 3'b010});
    assign misaligned = ((i_funct3[1:0] == 2'b01) && i_addr[0]) ||
                        ((i_funct3[1:0] == 2'b10) && (i_addr[1:0] != 2'b00));
    assign accept     = !i_rst && (state == IDLE) && isAccess && legalF3 && !misaligned;

    // Fault is decided from the live inputs so the offending instruction sees it at once.
    assign o_fault = !i_rst && (state == IDLE) && i_valid &&
                     ((i_load && i_store) || (isAccess && !(legalF3 && !misaligned)));
    assign o_stall = accept || (!i_rst && (state == WAIT));

    always_comb begin
        byteEn   = 4'b1111;
        laneData = i_storeData;
        if (i_store) begin
            case (i_funct3[1:0])
                2'b00: begin
                    byteEn   = 4'b0001 << i_addr[1:0];
                    laneData = {4{i_storeData[7:0]}};
                end
                2'b01: begin
                    byteEn   = 4'b0011 << {i_addr[1], 1'b0};
                    laneData = {2{i_storeData[15:0]}};
                end
                default: begin
                    byteEn   = 4'b1111;
                    laneData = i_storeData;
                end
            endcase
        end
    end

    assign shifted = i_memRData >> {addrLo, 3'b000};

    always_comb begin
        case (funct3Reg)
            3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  extended = {24'd0, shifted[7:0]};
            3'b101:  extended = {16'd0, shifted[15:0]};
            default: extended = shifted;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            addrLo      <= 2'b00;
            funct3Reg   <= 3'b000;
            isLoadReg   <= 1'b0;
            o_memReq    <= 1'b0;
            o_memWe     <= 1'b0;
            o_memAddr   <= '0;
            o_memByteEn <= 4'b0000;
            o_memWData  <= '0;
            o_loadData  <= '0;
            o_loadValid <= 1'b0;
        end else begin
            o_loadValid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        o_memReq    <= 1'b1;
                        o_memWe     <= i_store;
                        o_memAddr   <= {i_addr[XLEN-1:2], 2'b00};
                        o_memByteEn <= byteEn;
                        o_memWData  <= laneData;
                        addrLo      <= i_addr[1:0];
                        funct3Reg   <= i_funct3;
                        isLoadReg   <= i_load;
                        state       <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_memAck) begin
                        o_memReq <= 1'b0;
                        o_memWe  <= 1'b0;
                        if (isLoadReg) begin
                            o_loadData  <= extended;
                            o_loadValid <= 1'b1;
                        end
                        state <= RESP;
                    end
                end
                // The completed instruction is still presented here, so inputs are ignored.
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
